ips2l_uart_tx_32bit: RTL and testbench



---
 rtl/ips2l_uart_tx_pkg.sv | 31 +++
 rtl/ips2l_uart_tx_fifo_32bit.sv | 86 ++++++++
 rtl/ips2l_uart_tx_32bit.sv | 216 +++++++++++++++++++++
 tb/tb_ips2l_uart_tx_32bit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ips2l_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// ips2l_uart_tx_pkg
//
// Shared definitions for the 32-bit UART transmit stage: the transmitter state
// encoding and the word/byte geometry used by the FIFO and the serializer.
//
// Configuration macro: UART_TX_PARITY_EN (adds the even-parity helper).
// -----------------------------------------------------------------------------
package ips2l_uart_tx_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BITS_PER_BYTE;

    // PARITY is only ever entered when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [BITS_PER_BYTE-1:0] b);
        return ^b;
    endfunction
`endif

endpackage : ips2l_uart_tx_pkg

// File: rtl/ips2l_uart_tx_fifo_32bit.sv
// -----------------------------------------------------------------------------
// ips2l_uart_tx_fifo_32bit
//
// Synchronous word FIFO with show-ahead read data and registered full/empty.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (pointers and flags)
//   push_i       in   write request; ignored while full
//   push_data_i  in   word to write
//   pop_i        in   read request; ignored while empty
//   rd_data_o    out  word at the head of the FIFO (valid while !empty_o)
//   full_o       out  FIFO holds FIFO_DEPTH words
//   empty_o      out  FIFO holds no words
//
// Parameters:
//   FIFO_DEPTH   depth in words; power of 2, >= 2
// -----------------------------------------------------------------------------
module ips2l_uart_tx_fifo_32bit
    import ips2l_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // One extra pointer bit tells a full FIFO from an empty one after wrap.
    localparam int PW = AW + 1;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok, pop_ok;

    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        // A push while full is refused even if a pop happens in the same cycle.
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers is enough to
    // discard its contents, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule : ips2l_uart_tx_fifo_32bit

// File: rtl/ips2l_uart_tx_32bit.sv
// -----------------------------------------------------------------------------
// ips2l_uart_tx_32bit
//
// UART transmit stage behind the 32-bit control block. Words arrive on the
// tx_fifo_wr_* request/acknowledge handshake, are buffered in a word FIFO and
// are sent as four UART frames each, byte 0 (bits [7:0]) first, LSB first.
//
// Ports:
//   clk                    in   clock, rising edge
//   rst                    in   synchronous active-high reset
//   tx_fifo_wr_data        in   32-bit word from the control block
//   tx_fifo_wr_data_req    in   write request, data held stable until acked
//   tx_fifo_wr_data_valid  out  one-cycle acknowledge: word accepted
//   uart_tx                out  serial line, idles high, driven from a flop
//   fifo_full              out  FIFO holds FIFO_DEPTH words
//   fifo_empty             out  FIFO holds no words
//   tx_busy                out  a frame is in progress
//
// Parameters:
//   CLK_DIV     clock cycles per UART bit (>= 2)
//   FIFO_DEPTH  word FIFO depth (power of 2, >= 2)
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   : 8E1 frames (even parity bit between data and stop)
//   undefined : 8N1 frames, no parity logic
// -----------------------------------------------------------------------------
module ips2l_uart_tx_32bit
    import ips2l_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 72,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] tx_fifo_wr_data,
    input  logic              tx_fifo_wr_data_req,
    output logic              tx_fifo_wr_data_valid,
    output logic              uart_tx,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              tx_busy
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(BITS_PER_BYTE);
    localparam int BYTE_W = $clog2(BYTES_PER_WORD);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);

    tx_state_e          state_q, state_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic               pop;
    logic               baud_last;
    logic [WORD_W-1:0]  fifo_rd_data;
    logic               fifo_full_w;
    logic               fifo_empty_w;
    logic [BITS_PER_BYTE-1:0] cur_byte_d;

    // ------------------------------------------------------------------
    // Write handshake: the !valid term stops a second write of the same word
    // in the cycle the requester sees the ack and is still dropping req.
    // ------------------------------------------------------------------
    assign accept  = tx_fifo_wr_data_req && !fifo_full_w && !valid_q;
    assign valid_d = accept;

    ips2l_uart_tx_fifo_32bit #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .push_data_i (tx_fifo_wr_data),
        .pop_i       (pop),
        .rd_data_o   (fifo_rd_data),
        .full_o      (fifo_full_w),
        .empty_o     (fifo_empty_w)
    );

    // ------------------------------------------------------------------
    // Serializer FSM: next state and counters.
    // ------------------------------------------------------------------
    assign baud_last = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty_w) begin
                    pop        = 1'b1;
                    shift_d    = fifo_rd_data;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    state_d    = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (byte_cnt_q != BYTE_LAST) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        shift_d    = shift_q >> BITS_PER_BYTE;
                        state_d    = ST_START;
                    end else if (!fifo_empty_w) begin
                        // Chain straight into the next word with no idle gap.
                        pop        = 1'b1;
                        shift_d    = fifo_rd_data;
                        byte_cnt_d = '0;
                        state_d    = ST_START;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
            end

            default: begin
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line level is computed from the *next* state so it can be registered
    // and still change on the same edge as the state.
    // ------------------------------------------------------------------
    assign cur_byte_d = shift_d[BITS_PER_BYTE-1:0];

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = cur_byte_d[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(cur_byte_d);
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            valid_q    <= valid_d;
        end
    end

    assign uart_tx               = tx_q;
    assign tx_fifo_wr_data_valid = valid_q;
    assign fifo_full             = fifo_full_w;
    assign fifo_empty            = fifo_empty_w;
    assign tx_busy               = (state_q != ST_IDLE);

endmodule : ips2l_uart_tx_32bit

// File: tb/tb_ips2l_uart_tx_32bit.sv
// -----------------------------------------------------------------------------
// tb_ips2l_uart_tx_32bit
//
// Self-checking bench for ips2l_uart_tx_32bit with CLK_DIV=4, FIFO_DEPTH=4.
// The expected line waveform is generated from the frame format (start bit,
// eight data bits LSB first, optional even parity, stop bit, CLK_DIV cycles
// per bit, four bytes per word, byte 0 first) and compared cycle by cycle
// against a log of uart_tx. Honours UART_TX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_ips2l_uart_tx_32bit;

    localparam int CD      = 4;
    localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYC = 4 * FRAME_BITS * CD;
    localparam int LOG_LEN  = 16384;

    logic        clk;
    logic        rst;
    logic [31:0] wr_data;
    logic        req;
    logic        valid;
    logic        uart_tx;
    logic        full;
    logic        empty;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-cycle logs, indexed by cycle number, sampled on the falling edge.
    logic tx_log    [LOG_LEN];
    logic busy_log  [LOG_LEN];
    logic ack_log   [LOG_LEN];
    logic empty_log [LOG_LEN];
    logic full_log  [LOG_LEN];

    logic [31:0] words_q [$];
    logic        exp_q   [$];

    ips2l_uart_tx_32bit #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .tx_fifo_wr_data       (wr_data),
        .tx_fifo_wr_data_req   (req),
        .tx_fifo_wr_data_valid (valid),
        .uart_tx               (uart_tx),
        .fifo_full             (full),
        .fifo_empty            (empty),
        .tx_busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOG_LEN) begin
            tx_log[cyc]    = uart_tx;
            busy_log[cyc]  = busy;
            ack_log[cyc]   = valid;
            empty_log[cyc] = empty;
            full_log[cyc]  = full;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // Raise req with data, wait (bounded) for the ack, drop req.
    task automatic push_word(input logic [31:0] w, input int max_cyc,
                             output int acc_cyc, output bit ok);
        ok      = 1'b0;
        acc_cyc = -1;
        wr_data = w;
        req     = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            step(1);
            if (valid === 1'b1) begin
                ok      = 1'b1;
                acc_cyc = cyc - 1;
                break;
            end
        end
        req = 1'b0;
    endtask

    // Reference line waveform for words_q, preceded by `lead` idle cycles.
    task automatic build_expected(input int lead);
        exp_q.delete();
        repeat (lead) exp_q.push_back(1'b1);
        foreach (words_q[i]) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] by;
                by = words_q[i][8*b +: 8];
                repeat (CD) exp_q.push_back(1'b0);
                for (int j = 0; j < 8; j++) repeat (CD) exp_q.push_back(by[j]);
`ifdef UART_TX_PARITY_EN
                repeat (CD) exp_q.push_back(^by);
`endif
                repeat (CD) exp_q.push_back(1'b1);
            end
        end
    endtask

    // Cycles in [from_c, to_c) where the line differs from exp_q (idle after).
    function automatic int wave_diffs(input int from_c, input int to_c);
        int d = 0;
        for (int c = from_c; c < to_c; c++) begin
            int   k;
            logic e;
            k = c - from_c;
            e = (k < exp_q.size()) ? exp_q[k] : 1'b1;
            if (tx_log[c] !== e) d++;
        end
        return d;
    endfunction

    function automatic int busy_cycles(input int from_c, input int to_c);
        int n = 0;
        for (int c = from_c; c < to_c; c++) if (busy_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int ack_cycles(input int from_c, input int to_c);
        int n = 0;
        for (int c = from_c; c < to_c; c++) if (ack_log[c] === 1'b1) n++;
        return n;
    endfunction

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1; req = 1'b0; wr_data = '0;
        step(3);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        step(3);
    endtask

    task automatic test_single_word();
        int n0, acc, end_c, d;
        bit ok;
        words_q = '{32'h4433_2211};
        n0 = cyc;
        push_word(words_q[0], 10, acc, ok);
        checks++; if (!ok || acc !== n0) begin errors++; $display("FAIL single_accept: ok=%0b accept cycle %0d want %0d", ok, acc, n0); end
        end_c = n0 + 2 + WORD_CYC;
        wait_until(end_c + 8);
        checks++; if (ack_log[n0+1] !== 1'b1 || ack_log[n0+2] !== 1'b0) begin errors++; $display("FAIL single_ack_pulse: ack N+1=%b N+2=%b want 1,0", ack_log[n0+1], ack_log[n0+2]); end
        checks++; if (empty_log[n0] !== 1'b1 || empty_log[n0+1] !== 1'b0) begin errors++; $display("FAIL single_empty_fall: N=%b N+1=%b want 1,0", empty_log[n0], empty_log[n0+1]); end
        checks++; if (tx_log[n0+1] !== 1'b1 || tx_log[n0+2] !== 1'b0) begin errors++; $display("FAIL single_start_latency: N+1=%b N+2=%b want 1,0", tx_log[n0+1], tx_log[n0+2]); end
        build_expected(2);
        d = wave_diffs(n0, end_c + 8);
        checks++; if (d !== 0) begin errors++; $display("FAIL single_waveform: %0d cycles differ, want 0", d); end
        d = busy_cycles(n0, end_c + 8);
        checks++; if (d !== WORD_CYC) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", d, WORD_CYC); end
        checks++; if (busy !== 1'b0 || uart_tx !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL single_end_idle: busy=%b tx=%b empty=%b want 0,1,1", busy, uart_tx, empty); end
    endtask

    task automatic test_back_to_back();
        int n0, acc0, acc1, s2, end_c, d;
        bit ok0, ok1;
        words_q = '{$urandom, $urandom};
        n0 = cyc;
        push_word(words_q[0], 10, acc0, ok0);
        push_word(words_q[1], 10, acc1, ok1);
        checks++; if (!ok0 || !ok1 || acc0 !== n0) begin errors++; $display("FAIL b2b_accept: ok=%0b%0b first accept %0d want %0d", ok0, ok1, acc0, n0); end
        s2    = n0 + 2 + WORD_CYC;
        end_c = n0 + 2 + 2 * WORD_CYC;
        wait_until(end_c + 8);
        checks++; if (tx_log[s2-1] !== 1'b1 || tx_log[s2] !== 1'b0) begin errors++; $display("FAIL b2b_gap: last stop=%b next start=%b want 1,0", tx_log[s2-1], tx_log[s2]); end
        checks++; if (empty_log[s2] !== 1'b1) begin errors++; $display("FAIL b2b_empty_after_pop: got %b want 1", empty_log[s2]); end
        build_expected(2);
        d = wave_diffs(n0, end_c + 8);
        checks++; if (d !== 0) begin errors++; $display("FAIL b2b_waveform: %0d cycles differ, want 0", d); end
        d = busy_cycles(n0, end_c + 8);
        checks++; if (d !== 2 * WORD_CYC) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", d, 2 * WORD_CYC); end
    endtask

    task automatic test_fifo_full();
        int n0, acc, acc0, end_c, d, stall_bad;
        bit ok, ok_all;
        words_q.delete();
        for (int i = 0; i < 6; i++) words_q.push_back($urandom);
        ok_all = 1'b1;
        n0 = cyc;
        push_word(words_q[0], 10, acc0, ok);
        ok_all &= ok;
        for (int i = 1; i < 5; i++) begin
            push_word(words_q[i], 10, acc, ok);
            ok_all &= ok;
        end
        checks++; if (!ok_all || acc0 !== n0) begin errors++; $display("FAIL full_fill_accept: ok=%0b first accept %0d want %0d", ok_all, acc0, n0); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
        // Hold word 6 while full: no ack may appear.
        stall_bad = 0;
        wr_data = words_q[5];
        req     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (valid !== 1'b0 || full !== 1'b1) stall_bad++;
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL full_stall: %0d cycles with ack or not full, want 0", stall_bad); end
        push_word(words_q[5], 400, acc, ok);
        checks++; if (!ok || acc !== n0 + 2 + WORD_CYC) begin errors++; $display("FAIL full_accept_after_pop: ok=%0b accept %0d want %0d", ok, acc, n0 + 2 + WORD_CYC); end
        end_c = n0 + 2 + 6 * WORD_CYC;
        wait_until(end_c + 8);
        build_expected(2);
        d = wave_diffs(n0, end_c + 8);
        checks++; if (d !== 0) begin errors++; $display("FAIL full_order_waveform: %0d cycles differ, want 0", d); end
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_end_idle: empty=%b busy=%b want 1,0", empty, busy); end
    endtask

    task automatic test_held_req();
        int n0, end_c, d, adj;
        logic [31:0] w;
        w = $urandom;
        words_q = '{w, w, w, w, w};
        n0 = cyc;
        wr_data = w;
        req     = 1'b1;
        step(10);
        req = 1'b0;
        end_c = n0 + 2 + 5 * WORD_CYC;
        wait_until(end_c + 8);
        d = ack_cycles(n0, n0 + 12);
        checks++; if (d !== 5) begin errors++; $display("FAIL held_ack_count: got %0d want 5", d); end
        adj = 0;
        for (int c = n0; c < n0 + 12; c++) if (ack_log[c] === 1'b1 && ack_log[c+1] === 1'b1) adj++;
        checks++; if (adj !== 0) begin errors++; $display("FAIL held_ack_width: %0d back-to-back acks, want 0", adj); end
        checks++; if (full_log[n0+8] !== 1'b0 || full_log[n0+9] !== 1'b1) begin errors++; $display("FAIL held_level: full at N+8=%b N+9=%b want 0,1", full_log[n0+8], full_log[n0+9]); end
        build_expected(2);
        d = wave_diffs(n0, end_c + 8);
        checks++; if (d !== 0) begin errors++; $display("FAIL held_waveform: %0d cycles differ, want 0", d); end
    endtask

    // Pushes words_q as fast as the handshake allows and checks the line.
    task automatic run_stream(input string name);
        int n0, acc, acc0, end_c, d;
        bit ok, ok_all;
        ok_all = 1'b1;
        acc0   = -1;
        n0     = cyc;
        foreach (words_q[i]) begin
            push_word(words_q[i], 400, acc, ok);
            ok_all &= ok;
            if (i == 0) acc0 = acc;
        end
        checks++; if (!ok_all || acc0 !== n0) begin errors++; $display("FAIL %s_accept: ok=%0b first accept %0d want %0d", name, ok_all, acc0, n0); end
        end_c = n0 + 2 + words_q.size() * WORD_CYC;
        wait_until(end_c + 8);
        build_expected(2);
        d = wave_diffs(n0, end_c + 8);
        checks++; if (d !== 0) begin errors++; $display("FAIL %s_waveform: %0d cycles differ, want 0", name, d); end
        d = busy_cycles(n0, end_c + 8);
        checks++; if (d !== words_q.size() * WORD_CYC) begin errors++; $display("FAIL %s_busy_len: got %0d want %0d", name, d, words_q.size() * WORD_CYC); end
    endtask

    task automatic test_patterns();
        // Includes 0x0000_0007: byte 0x07 has odd weight, so parity bit is 1.
        words_q = '{32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_5A5A};
        run_stream("patterns");
    endtask

    task automatic test_random_stream();
        for (int r = 0; r < 3; r++) begin
            int k;
            k = $urandom_range(1, 3);
            words_q.delete();
            for (int i = 0; i < k; i++) words_q.push_back($urandom);
            run_stream("random");
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0, acc, r, d;
        bit ok0, ok1;
        n0 = cyc;
        push_word($urandom, 10, acc, ok0);
        push_word($urandom, 10, acc, ok1);
        checks++; if (!ok0 || !ok1) begin errors++; $display("FAIL rstmid_accept: ok=%0b%0b want 11", ok0, ok1); end
        // Third data bit of byte 1.
        wait_until(n0 + 2 + FRAME_BITS * CD + 3 * CD);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        r = cyc;
        checks++; if (uart_tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL rstmid_after: tx=%b empty=%b busy=%b full=%b want 1,1,0,0", uart_tx, empty, busy, full); end
        wait_until(r + 2 * WORD_CYC);
        words_q.delete();
        build_expected(0);
        d = wave_diffs(r, cyc);
        checks++; if (d !== 0) begin errors++; $display("FAIL rstmid_line_idle: %0d cycles not high, want 0", d); end
        d = busy_cycles(r, cyc);
        checks++; if (d !== 0) begin errors++; $display("FAIL rstmid_busy: %0d busy cycles, want 0", d); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fifo_full();
        test_held_req();
        test_patterns();
        test_random_stream();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ips2l_uart_tx_32bit
